mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory (BRAM) port between two requesters: load issue from the load buffer, and store commit from the ROB head.
- Grants at most one access per cycle and drives the BRAM port.
- Tracks in-flight loads through a fixed-latency pipeline and returns load data tagged with its ROB index.
- On flush, drops all in-flight load results; store commits are never dropped.

Parameters:
- ROB_IX, 2: ROB index MSB; index width is ROB_IX+1.
- MEM_LATENCY, 2: BRAM read latency in cycles, >=1.
- STARVE_MAX, 2: consecutive store grants allowed while a load waits.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- flush_in  input  1  mispredict flush from ROB
- ld_valid_in  input  1  load buffer has an issuable entry
- ld_addr_in  input  32  load address
- ld_rob_ix_in  input  ROB_IX+1  load ROB tag
- ld_read_out  output  1  load accepted this cycle; drives load buffer read_in
- st_valid_in  input  1  ROB head store ready to commit
- st_addr_in  input  32  store address
- st_data_in  input  32  store data, pre-aligned
- st_byte_en_in  input  4  store byte enables
- st_ready_out  output  1  store accepted this cycle
- mem_en_out  output  1  BRAM enable
- mem_we_out  output  4  BRAM byte write enables
- mem_addr_out  output  32  BRAM address
- mem_din_out  output  32  BRAM write data
- mem_dout_in  input  32  BRAM read data
- ld_result_valid_out  output  1  load data valid
- ld_result_out  output  32  load data (raw word)
- ld_result_rob_ix_out  output  ROB_IX+1  tag of returning load
- inflight_out  output  $clog2(MEM_LATENCY+1)  count of in-flight loads

Behaviour:
- Clock and reset: single clock clk_in. rst_in is synchronous, active-high, and has priority over everything else.
- Arbitration (combinational, same cycle):
  - rst_in high: no grant.
  - Only one requester valid: that requester is granted, except a load is never granted while flush_in is high.
  - Both valid: store wins unless starve_cnt == STARVE_MAX, in which case the load wins.
- Starvation counter:
  - Increments (saturating) on a store grant while ld_valid_in is high and no load is granted.
  - Clears on any load grant, on flush, and on reset.
- Load grant:
  - ld_read_out=1, mem_en_out=1, mem_we_out=0, mem_addr_out=ld_addr_in.
  - Pushes {valid=1, ld_rob_ix_in} into the response pipeline.
- Store grant:
  - st_ready_out=1, mem_en_out=1, mem_we_out=st_byte_en_in, mem_addr_out=st_addr_in, mem_din_out=st_data_in.
  - Pushes valid=0 into the pipeline.
- No grant: mem_en_out=0, mem_we_out=0, pipeline pushes valid=0. mem_addr_out and mem_din_out are don't-care but held at 0.
- Response pipeline:
  - MEM_LATENCY-stage shift register of {valid, rob_ix}.
  - Stage MEM_LATENCY-1 drives ld_result_valid_out and ld_result_rob_ix_out.
  - ld_result_out = mem_dout_in (combinational).
  - A load granted in cycle t returns in cycle t+MEM_LATENCY.
- Back-to-back throughput: one access per cycle, any mix of loads and stores.
- RAW ordering: a store granted in cycle t is visible to a load granted in cycle t+1 or later. No forwarding is needed.
- Flush: on an edge with flush_in=1:
  - All pipeline valid bits clear.
  - ld_result_valid_out is also forced 0 combinationally in the flush cycle.
  - A store granted in the flush cycle still writes.
- Reset values:
  - Pipeline valid bits and rob_ix fields 0; starve_cnt 0.
  - All outputs 0 during and after reset until a request arrives.
- inflight_out: popcount of pipeline valid bits.
- Simultaneous flush_in and ld_valid_in: no load grant, ld_read_out=0. The load buffer is itself cleared by the flush.

Decomposition:
- Shared package (types.svh) additions:
  - MEM_LATENCY default constant.
  - Typedef mem_req_t {en, we[3:0], addr[31:0], din[31:0]}.
  - Typedef ld_tag_t {valid, rob_ix}.
- One natural sub-module: ld_resp_pipe, a parameterized valid/tag shift register with synchronous clear.

Test Plan:
1. Load only: ld_valid_in=1, addr=0x10, rob_ix=3, memory[0x10]=0xDEADBEEF -> ld_read_out=1 at t; at t+2 ld_result_valid_out=1, ld_result_out=0xDEADBEEF, ld_result_rob_ix_out=3.
2. Store then load to same address: store 0x12345678 to 0x20 (byte_en=4'hF) at t, load 0x20 tag 1 at t+1 -> result 0x12345678 at t+3.
3. Contention: st_valid_in and ld_valid_in held high for 6 cycles -> grant sequence S,S,L,S,S,L; starve_cnt resets after each L.
4. Flush mid-flight: loads tags 1 and 2 granted at t and t+1, flush_in at t+1 -> tag 2 not granted, no ld_result_valid_out at t+2 or t+3, inflight_out=0 at t+2.
5. Flush with store: st_valid_in and flush_in both high at t with addr 0x30, data 0xA5A5A5A5 -> st_ready_out=1, mem_we_out=4'hF, later load from 0x30 returns 0xA5A5A5A5.
6. Reset mid-operation: rst_in at t+1 after a load grant at t -> no result returned, all outputs 0, next load behaves as in test 1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared defaults and types for the data-memory port arbiter: the BRAM request
// bundle, the in-flight load tag and the per-cycle grant decision.
package mem_port_arbiter_pkg;

    localparam int ROB_IX_DEFAULT      = 2;
    localparam int MEM_LATENCY_DEFAULT = 2;
    localparam int STARVE_MAX_DEFAULT  = 2;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_LOAD,
        GRANT_STORE
    } grant_e;

    typedef struct packed {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] din;
    } mem_req_t;

    typedef struct packed {
        logic                    valid;
        logic [ROB_IX_DEFAULT:0] rob_ix;
    } ld_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request, BRAM and load-response signals around the memory-port arbiter.
// The arbiter sits on the slave modport; load buffer, ROB and BRAM on master.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ROB_IX      = ROB_IX_DEFAULT,
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
);

    logic                               flush_in;

    logic                               ld_valid_in;
    logic [31:0]                        ld_addr_in;
    logic [ROB_IX:0]                    ld_rob_ix_in;
    logic                               ld_read_out;

    logic                               st_valid_in;
    logic [31:0]                        st_addr_in;
    logic [31:0]                        st_data_in;
    logic [3:0]                         st_byte_en_in;
    logic                               st_ready_out;

    logic                               mem_en_out;
    logic [3:0]                         mem_we_out;
    logic [31:0]                        mem_addr_out;
    logic [31:0]                        mem_din_out;
    logic [31:0]                        mem_dout_in;

    logic                               ld_result_valid_out;
    logic [31:0]                        ld_result_out;
    logic [ROB_IX:0]                    ld_result_rob_ix_out;
    logic [$clog2(MEM_LATENCY+1)-1:0]   inflight_out;

    modport slave (
        input  flush_in,
        input  ld_valid_in, ld_addr_in, ld_rob_ix_in,
        output ld_read_out,
        input  st_valid_in, st_addr_in, st_data_in, st_byte_en_in,
        output st_ready_out,
        output mem_en_out, mem_we_out, mem_addr_out, mem_din_out,
        input  mem_dout_in,
        output ld_result_valid_out, ld_result_out, ld_result_rob_ix_out,
        output inflight_out
    );

    modport master (
        output flush_in,
        output ld_valid_in, ld_addr_in, ld_rob_ix_in,
        input  ld_read_out,
        output st_valid_in, st_addr_in, st_data_in, st_byte_en_in,
        input  st_ready_out,
        input  mem_en_out, mem_we_out, mem_addr_out, mem_din_out,
        output mem_dout_in,
        input  ld_result_valid_out, ld_result_out, ld_result_rob_ix_out,
        input  inflight_out
    );

endinterface

// File: rtl/mem_port_arbiter_ld_resp_pipe.sv
// Fixed-depth shift register of {valid, rob_ix} tags that mirrors the BRAM read
// latency; a clear drops every in-flight entry.
module mem_port_arbiter_ld_resp_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int  DEPTH = MEM_LATENCY_DEFAULT,
    parameter type tag_t = ld_tag_t
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         clear_in,
    input  tag_t                         push_in,
    output tag_t                         tail_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    tag_t stage_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tail_out = stage_q[DEPTH-1];

    always_comb begin
        count_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_out = count_out + CNT_W'(stage_q[i].valid);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single BRAM port between load issue and store commit, one access
// per cycle, and returns load data tagged with its ROB index after MEM_LATENCY.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ROB_IX      = ROB_IX_DEFAULT,
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT,
    parameter int STARVE_MAX  = STARVE_MAX_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_port_arbiter_if.slave bus
);

    localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int CNT_W    = $clog2(MEM_LATENCY + 1);

    typedef struct packed {
        logic            valid;
        logic [ROB_IX:0] rob_ix;
    } rob_tag_t;

    grant_e              grant;
    logic [STARVE_W-1:0] starve_q;
    logic                starved;
    logic                ld_req;
    mem_req_t            req;
    rob_tag_t            push;
    rob_tag_t            tail;
    logic [CNT_W-1:0]    inflight;

    assign ld_req  = bus.ld_valid_in && !bus.flush_in;
    assign starved = (starve_q == STARVE_W'(STARVE_MAX));

    // Store commit normally wins; a load that has been passed over STARVE_MAX times takes the port.
    always_comb begin
        grant = GRANT_NONE;
        if (!rst_in) begin
            if (ld_req && (!bus.st_valid_in || starved)) begin
                grant = GRANT_LOAD;
            end else if (bus.st_valid_in) begin
                grant = GRANT_STORE;
            end
        end
    end

    always_comb begin
        req  = '0;
        push = '0;
        case (grant)
            GRANT_LOAD: begin
                req.en      = 1'b1;
                req.addr    = bus.ld_addr_in;
                push.valid  = 1'b1;
                push.rob_ix = bus.ld_rob_ix_in;
            end
            GRANT_STORE: begin
                req.en   = 1'b1;
                req.we   = bus.st_byte_en_in;
                req.addr = bus.st_addr_in;
                req.din  = bus.st_data_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || bus.flush_in || grant == GRANT_LOAD) begin
            starve_q <= '0;
        end else if (grant == GRANT_STORE && bus.ld_valid_in && !starved) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end

    mem_port_arbiter_ld_resp_pipe #(
        .DEPTH (MEM_LATENCY),
        .tag_t (rob_tag_t)
    ) u_ld_resp_pipe (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (bus.flush_in),
        .push_in   (push),
        .tail_out  (tail),
        .count_out (inflight)
    );

    assign bus.ld_read_out  = (grant == GRANT_LOAD);
    assign bus.st_ready_out = (grant == GRANT_STORE);
    assign bus.mem_en_out   = req.en;
    assign bus.mem_we_out   = req.we;
    assign bus.mem_addr_out = req.addr;
    assign bus.mem_din_out  = req.din;

    // A result reaching the pipe tail in a flush cycle belongs to a squashed load.
    assign bus.ld_result_valid_out  = tail.valid && !bus.flush_in && !rst_in;
    assign bus.ld_result_out        = bus.mem_dout_in;
    assign bus.ld_result_rob_ix_out = rst_in ? '0 : tail.rob_ix;
    assign bus.inflight_out         = rst_in ? '0 : inflight;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a BRAM stand-in, a queue-based
// reference model checked every cycle, and directed scenarios with literal values.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int ROB_IX      = ROB_IX_DEFAULT;
    localparam int MEM_LATENCY = MEM_LATENCY_DEFAULT;
    localparam int STARVE_MAX  = STARVE_MAX_DEFAULT;
    localparam int TAG_W       = ROB_IX + 1;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ROB_IX(ROB_IX), .MEM_LATENCY(MEM_LATENCY)) bus ();

    mem_port_arbiter #(
        .ROB_IX      (ROB_IX),
        .MEM_LATENCY (MEM_LATENCY),
        .STARVE_MAX  (STARVE_MAX)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d actual=0x%h expected=0x%h", name, cyc, actual, expected);
        end
    endtask

    // BRAM stand-in: request sampled mid-cycle, applied at the edge, read data after MEM_LATENCY edges.
    logic [31:0] bram [256];
    logic [31:0] rd_q [MEM_LATENCY] = '{default: '0};
    logic        bram_ready = 1'b0;
    logic        cap_en = 1'b0;
    logic [3:0]  cap_we = '0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_din = '0;

    always @(negedge clk) begin
        cap_en   <= bus.mem_en_out;
        cap_we   <= bus.mem_we_out;
        cap_addr <= bus.mem_addr_out;
        cap_din  <= bus.mem_din_out;
    end

    always @(posedge clk) begin
        for (int i = 1; i < MEM_LATENCY; i++) rd_q[i] <= rd_q[i-1];
        if (!bram_ready) begin
            for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
            bram_ready <= 1'b1;
            rd_q[0]    <= '0;
        end else begin
            rd_q[0] <= (cap_en && cap_we == 4'h0) ? bram[cap_addr[9:2]] : 32'h0;
            if (cap_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (cap_we[b]) bram[cap_addr[9:2]][8*b +: 8] <= cap_din[8*b +: 8];
                end
            end
        end
    end

    assign bus.mem_dout_in = rd_q[MEM_LATENCY-1];

    // Reference model: grants from the arbitration rules, returns as a queue of due cycles.
    typedef struct {
        int               due;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } ret_t;

    ret_t        ret_q[$];
    logic [31:0] refmem [256];
    int          starve;
    logic        model_ready = 1'b0;

    always @(negedge clk) begin
        logic        exp_ld, exp_st, ld_ok, exp_rv;
        logic [3:0]  exp_we;
        logic [31:0] exp_addr, exp_din;
        int          exp_infl;
        ret_t        head;

        if (!model_ready) begin
            for (int i = 0; i < 256; i++) refmem[i] = init_word(i);
            starve      = 0;
            model_ready = 1'b1;
        end

        exp_ld = 1'b0;
        exp_st = 1'b0;
        if (!rst) begin
            ld_ok = bus.ld_valid_in && !bus.flush_in;
            if (ld_ok && bus.st_valid_in) begin
                if (starve == STARVE_MAX) exp_ld = 1'b1;
                else                      exp_st = 1'b1;
            end else if (ld_ok) begin
                exp_ld = 1'b1;
            end else if (bus.st_valid_in) begin
                exp_st = 1'b1;
            end
        end
        exp_we   = exp_st ? bus.st_byte_en_in : 4'h0;
        exp_addr = exp_ld ? bus.ld_addr_in : (exp_st ? bus.st_addr_in : 32'h0);
        exp_din  = exp_st ? bus.st_data_in : 32'h0;

        exp_infl = rst ? 0 : ret_q.size();
        exp_rv   = 1'b0;
        head     = '{due: 0, tag: '0, data: '0};
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            head   = ret_q.pop_front();
            exp_rv = !rst && !bus.flush_in;
        end

        check_output("ld_read",   32'(bus.ld_read_out),  32'(exp_ld));
        check_output("st_ready",  32'(bus.st_ready_out), 32'(exp_st));
        check_output("mem_en",    32'(bus.mem_en_out),   32'(exp_ld | exp_st));
        check_output("mem_we",    32'(bus.mem_we_out),   32'(exp_we));
        check_output("mem_addr",  bus.mem_addr_out,      exp_addr);
        check_output("mem_din",   bus.mem_din_out,       exp_din);
        check_output("res_valid", 32'(bus.ld_result_valid_out), 32'(exp_rv));
        check_output("inflight",  32'(bus.inflight_out), 32'(exp_infl));
        if (exp_rv) begin
            check_output("res_data", bus.ld_result_out,              head.data);
            check_output("res_tag",  32'(bus.ld_result_rob_ix_out),  32'(head.tag));
        end

        if (rst) begin
            ret_q.delete();
            starve = 0;
        end else begin
            if (bus.flush_in) ret_q.delete();
            if (exp_ld) ret_q.push_back('{due: cyc + MEM_LATENCY, tag: bus.ld_rob_ix_in,
                                           data: refmem[bus.ld_addr_in[9:2]]});
            if (exp_st) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.st_byte_en_in[b])
                        refmem[bus.st_addr_in[9:2]][8*b +: 8] = bus.st_data_in[8*b +: 8];
                end
            end
            if (bus.flush_in || exp_ld)                              starve = 0;
            else if (exp_st && bus.ld_valid_in && starve < STARVE_MAX) starve++;
        end
        cyc++;
    end

    task automatic apply_stimulus(input logic ld_v, input logic [31:0] ld_a, input logic [TAG_W-1:0] tag,
                                  input logic st_v, input logic [31:0] st_a, input logic [31:0] st_d,
                                  input logic [3:0] be, input logic fl, input logic r);
        @(posedge clk);
        #1;
        bus.ld_valid_in   = ld_v;
        bus.ld_addr_in    = ld_a;
        bus.ld_rob_ix_in  = tag;
        bus.st_valid_in   = st_v;
        bus.st_addr_in    = st_a;
        bus.st_data_in    = st_d;
        bus.st_byte_en_in = be;
        bus.flush_in      = fl;
        rst               = r;
    endtask

    task automatic idle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst               = 1'b1;
        bus.flush_in      = 1'b0;
        bus.ld_valid_in   = 1'b0;
        bus.ld_addr_in    = '0;
        bus.ld_rob_ix_in  = '0;
        bus.st_valid_in   = 1'b0;
        bus.st_addr_in    = '0;
        bus.st_data_in    = '0;
        bus.st_byte_en_in = '0;

        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        check_output("rst_mem_en",   32'(bus.mem_en_out),          0);
        check_output("rst_inflight", 32'(bus.inflight_out),        0);
        idle();
        #1;
        check_output("idle_addr",  bus.mem_addr_out,                0);
        check_output("idle_valid", 32'(bus.ld_result_valid_out),    0);
        check_output("idle_tag",   32'(bus.ld_result_rob_ix_out),   0);

        // Load only
        apply_stimulus(1, 32'h10, 3, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("t1_read", 32'(bus.ld_read_out), 1);
        check_output("t1_addr", bus.mem_addr_out, 32'h10);
        idle();
        #1;
        check_output("t1_inflight", 32'(bus.inflight_out), 1);
        idle();
        #1;
        check_output("t1_valid", 32'(bus.ld_result_valid_out), 1);
        check_output("t1_data",  bus.ld_result_out, 32'hDEADBEEF);
        check_output("t1_tag",   32'(bus.ld_result_rob_ix_out), 3);

        // Store then load to the same address
        apply_stimulus(0, 0, 0, 1, 32'h20, 32'h12345678, 4'hF, 0, 0);
        #1;
        check_output("t2_we", 32'(bus.mem_we_out), 32'hF);
        apply_stimulus(1, 32'h20, 1, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        #1;
        check_output("t2_valid", 32'(bus.ld_result_valid_out), 1);
        check_output("t2_data",  bus.ld_result_out, 32'h12345678);
        check_output("t2_tag",   32'(bus.ld_result_rob_ix_out), 1);

        // Contention: S,S,L,S,S,L
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1, 32'h10, TAG_W'(k), 1, 32'h40, 32'(k), 4'hF, 0, 0);
            #1;
            check_output("t3_read",  32'(bus.ld_read_out),  32'((k == 2) || (k == 5)));
            check_output("t3_ready", 32'(bus.st_ready_out), 32'((k != 2) && (k != 5)));
        end
        repeat (3) idle();

        // Flush mid-flight
        apply_stimulus(1, 32'h10, 1, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 32'h20, 2, 0, 0, 0, 0, 1, 0);
        #1;
        check_output("t4_read", 32'(bus.ld_read_out), 0);
        idle();
        #1;
        check_output("t4_valid2",    32'(bus.ld_result_valid_out), 0);
        check_output("t4_inflight2", 32'(bus.inflight_out), 0);
        idle();
        #1;
        check_output("t4_valid3", 32'(bus.ld_result_valid_out), 0);

        // Store during flush still writes
        apply_stimulus(0, 0, 0, 1, 32'h30, 32'hA5A5A5A5, 4'hF, 1, 0);
        #1;
        check_output("t5_ready", 32'(bus.st_ready_out), 1);
        check_output("t5_we",    32'(bus.mem_we_out), 32'hF);
        apply_stimulus(1, 32'h30, 5, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        #1;
        check_output("t5_data", bus.ld_result_out, 32'hA5A5A5A5);
        check_output("t5_tag",  32'(bus.ld_result_rob_ix_out), 5);

        // Reset mid-operation
        apply_stimulus(1, 32'h10, 3, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        check_output("t6_rst_en",    32'(bus.mem_en_out), 0);
        check_output("t6_rst_infl",  32'(bus.inflight_out), 0);
        idle();
        #1;
        check_output("t6_valid", 32'(bus.ld_result_valid_out), 0);
        idle();
        apply_stimulus(1, 32'h10, 3, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        #1;
        check_output("t6_data", bus.ld_result_out, 32'hDEADBEEF);
        check_output("t6_tag",  32'(bus.ld_result_rob_ix_out), 3);

        // Randomized traffic over a small address window so loads often hit recent stores
        repeat (1500) begin
            apply_stimulus($urandom_range(0, 99) < 60,
                           32'($urandom_range(0, 15)) << 2,
                           TAG_W'($urandom_range(0, (1 << TAG_W) - 1)),
                           $urandom_range(0, 99) < 50,
                           32'($urandom_range(0, 15)) << 2,
                           $urandom,
                           4'($urandom_range(0, 15)),
                           $urandom_range(0, 99) < 5,
                           $urandom_range(0, 99) < 1);
        end
        repeat (4) idle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
